// File: rtl/button_conditioner.sv
// N-channel button front end: debounce, press pulse, DAS/ARR auto-repeat and press-length
// classification, mode selectable per channel. Define BTN_SYNC_EN to add a 2-flop synchroniser.
module button_conditioner #(
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DAS_CYCLES      = 10000000,
    parameter int unsigned ARR_CYCLES      = 3000000,
    parameter int unsigned MEDIUM_CYCLES   = 50000000,
    parameter int unsigned LONG_CYCLES     = 150000000
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [N_BTN-1:0]   btn_in,
    input  logic [2*N_BTN-1:0] mode_in,
    output logic [N_BTN-1:0]   level_out,
    output logic [N_BTN-1:0]   event_out,
    output logic [N_BTN-1:0]   short_out,
    output logic [N_BTN-1:0]   medium_out,
    output logic [N_BTN-1:0]   long_out
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned H_W    = $clog2(LONG_CYCLES + 1);
    localparam int unsigned R_W    = $clog2(DAS_CYCLES + ARR_CYCLES);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [H_W-1:0]    H_MAX     = H_W'(LONG_CYCLES);
    localparam logic [H_W-1:0]    MED_LAST  = H_W'(MEDIUM_CYCLES - 1);
    localparam logic [R_W-1:0]    R_DAS     = R_W'(DAS_CYCLES);
    localparam logic [R_W-1:0]    R_LAST    = R_W'(DAS_CYCLES + ARR_CYCLES - 1);

    localparam logic [1:0] MODE_PULSE    = 2'b00;
    localparam logic [1:0] MODE_REPEAT   = 2'b01;
    localparam logic [1:0] MODE_CLASSIFY = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StLockout
    } state_e;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic              raw;
        logic [1:0]        mode_cur;
        logic              clean_q, clean_d;
        logic [DCNT_W-1:0] dcnt_q, dcnt_d;
        logic [H_W-1:0]    h_q, h_d;
        logic [R_W-1:0]    rcnt_q, rcnt_d;
        state_e            state_q, state_d;
        logic [1:0]        mode_q, mode_d;
        logic              long_done_q, long_done_d;
        logic              first;
        logic              event_q, event_d;
        logic              short_q, short_d;
        logic              medium_q, medium_d;
        logic              long_q, long_d;

        assign mode_cur = mode_in[2*i +: 2];

`ifdef BTN_SYNC_EN
        logic sync1_q, sync2_q;

        always_ff @(posedge clk_in) begin
            if (reset_in) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= btn_in[i];
                sync2_q <= sync1_q;
            end
        end

        assign raw = sync2_q;
`else
        assign raw = btn_in[i];
`endif

        always_comb begin
            clean_d = clean_q;
            dcnt_d  = '0;
            if (raw != clean_q) begin
                if (dcnt_q == DCNT_LAST) begin
                    clean_d = raw;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        end

        assign first = clean_d & ~clean_q;

        // rcnt runs 0..DAS, then cycles DAS..DAS+ARR-1 so every return to DAS is a repeat
        always_comb begin
            h_d    = '0;
            rcnt_d = '0;
            if (clean_d && clean_q) begin
                h_d    = (h_q == H_MAX) ? h_q : h_q + 1'b1;
                rcnt_d = (rcnt_q == R_LAST) ? R_DAS : rcnt_q + 1'b1;
            end
        end

        always_comb begin
            state_d = state_q;
            mode_d  = mode_q;
            case (state_q)
                StIdle: begin
                    if (clean_d) begin
                        state_d = StHeld;
                        mode_d  = mode_cur;
                    end
                end
                StHeld: begin
                    if (!clean_d) begin
                        state_d = StIdle;
                    end else if (mode_cur != mode_q) begin
                        state_d = StLockout;
                    end
                end
                StLockout: begin
                    if (!clean_d) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_comb begin
            event_d     = 1'b0;
            short_d     = 1'b0;
            medium_d    = 1'b0;
            long_d      = 1'b0;
            long_done_d = 1'b0;
            if (state_d == StHeld) begin
                long_done_d = long_done_q;
                case (mode_d)
                    MODE_PULSE:  event_d = first;
                    MODE_REPEAT: event_d = (rcnt_d == '0) || (rcnt_d == R_DAS);
                    MODE_CLASSIFY: begin
                        long_d      = (h_d == H_MAX) && !long_done_q;
                        long_done_d = long_done_q | long_d;
                    end
                    default: ;
                endcase
            end
            // Release of a normal hold: h_q is the last high cycle's count, so H = h_q + 1
            if (state_q == StHeld && !clean_d && mode_q == MODE_CLASSIFY && !long_done_q) begin
                if (h_q < MED_LAST) begin
                    short_d = 1'b1;
                end else begin
                    medium_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_in) begin
            if (reset_in) begin
                clean_q     <= 1'b0;
                dcnt_q      <= '0;
                h_q         <= '0;
                rcnt_q      <= '0;
                state_q     <= StIdle;
                mode_q      <= MODE_PULSE;
                long_done_q <= 1'b0;
                event_q     <= 1'b0;
                short_q     <= 1'b0;
                medium_q    <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                clean_q     <= clean_d;
                dcnt_q      <= dcnt_d;
                h_q         <= h_d;
                rcnt_q      <= rcnt_d;
                state_q     <= state_d;
                mode_q      <= mode_d;
                long_done_q <= long_done_d;
                event_q     <= event_d;
                short_q     <= short_d;
                medium_q    <= medium_d;
                long_q      <= long_d;
            end
        end

        assign level_out[i]  = clean_q;
        assign event_out[i]  = event_q;
        assign short_out[i]  = short_q;
        assign medium_out[i] = medium_q;
        assign long_out[i]   = long_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with small timing parameters.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic [5:0] mode;
    logic [2:0] level, ev, sh, md, lg;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN          (3),
        .DEBOUNCE_CYCLES(4),
        .DAS_CYCLES     (10),
        .ARR_CYCLES     (3),
        .MEDIUM_CYCLES  (20),
        .LONG_CYCLES    (50)
    ) dut (
        .clk_in    (clk),
        .reset_in  (rst),
        .btn_in    (btn),
        .mode_in   (mode),
        .level_out (level),
        .event_out (ev),
        .short_out (sh),
        .medium_out(md),
        .long_out  (lg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Filled by hold_channel for the scenario tasks to judge
    int ev_h[$];
    int long_h[$];
    int rise_delay, rel_h, hold_short, hold_med, post_cnt, other_cnt;
    logic rel_ev, rel_sh, rel_md, rel_lg;
    bit timed_out;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press channel ch so level stays high for exactly `hold` cycles; optionally change
    // its mode after the cycle observed at h == chg_h.
    task automatic hold_channel(input int ch, input int hold, input int chg_h,
                                input logic [1:0] chg_mode);
        logic [2:0] om;
        bit done;
        om = 3'b111 ^ (3'b001 << ch);
        ev_h.delete();
        long_h.delete();
        rise_delay = 0; rel_h = -1; hold_short = 0; hold_med = 0; post_cnt = 0; other_cnt = 0;
        rel_ev = 1'b0; rel_sh = 1'b0; rel_md = 1'b0; rel_lg = 1'b0;
        timed_out = 1'b0;
        btn[ch] = 1'b1;
        while (level[ch] !== 1'b1 && rise_delay < 20) begin
            tick();
            rise_delay++;
            if (level[ch] !== 1'b1 && (|(ev | sh | md | lg))) other_cnt++;
        end
        if (level[ch] !== 1'b1) begin
            timed_out = 1'b1;
        end else begin
            done = 1'b0;
            for (int h = 0; h <= hold + 8 && !done; h++) begin
                if (level[ch] !== 1'b1) begin
                    rel_h = h; rel_ev = ev[ch]; rel_sh = sh[ch]; rel_md = md[ch]; rel_lg = lg[ch];
                    if (|((level | ev | sh | md | lg) & om)) other_cnt++;
                    done = 1'b1;
                end else begin
                    if (ev[ch] === 1'b1) ev_h.push_back(h);
                    if (lg[ch] === 1'b1) long_h.push_back(h);
                    if (sh[ch] === 1'b1) hold_short++;
                    if (md[ch] === 1'b1) hold_med++;
                    if (|((level | ev | sh | md | lg) & om)) other_cnt++;
                    if (h == hold - 4) btn[ch] = 1'b0;
                    if (h == chg_h) mode[2*ch +: 2] = chg_mode;
                    tick();
                end
            end
            if (!done) timed_out = 1'b1;
        end
        btn[ch] = 1'b0;
        repeat (6) begin
            tick();
            if (|(ev | sh | md | lg)) post_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 3'b000;
        mode = 6'b111111;
        repeat (3) tick();
        n_checks++; if (level !== 3'b000) begin n_fail++; $display("FAIL reset_level: got %b expected 000", level); end
        n_checks++; if ((ev | sh | md | lg) !== 3'b000) begin n_fail++; $display("FAIL reset_events: got %b expected 000", ev | sh | md | lg); end
        rst = 1'b0;
        tick();
        n_checks++; if (level !== 3'b000) begin n_fail++; $display("FAIL reset_release_level: got %b expected 000", level); end
    endtask

    task automatic test_glitch();
        int bad, d;
        bad = 0;
        mode[1:0] = 2'b11;
        btn[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (|(level | ev | sh | md | lg)) bad++;
        end
        btn[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (|(level | ev | sh | md | lg)) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL glitch_quiet: got %0d active cycles expected 0", bad); end
        btn[0] = 1'b1;
        d = 0;
        while (level[0] !== 1'b1 && d < 20) begin tick(); d++; end
        n_checks++; if (d !== 4) begin n_fail++; $display("FAIL glitch_rise_delay: got %0d expected 4", d); end
        btn[0] = 1'b0;
        repeat (8) tick();
        n_checks++; if (level !== 3'b000) begin n_fail++; $display("FAIL glitch_release: got %b expected 000", level); end
    endtask

    task automatic test_pulse();
        int first;
        mode[1:0] = 2'b00;
        hold_channel(0, 30, -1, 2'b00);
        first = (ev_h.size() > 0) ? ev_h[0] : -1;
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL pulse_timeout: got %0d expected 0", timed_out); end
        n_checks++; if (rise_delay !== 4) begin n_fail++; $display("FAIL pulse_rise_delay: got %0d expected 4", rise_delay); end
        n_checks++; if (ev_h.size() !== 1) begin n_fail++; $display("FAIL pulse_count: got %0d expected 1", ev_h.size()); end
        n_checks++; if (first !== 0) begin n_fail++; $display("FAIL pulse_position: got h=%0d expected h=0", first); end
        n_checks++; if (rel_h !== 30) begin n_fail++; $display("FAIL pulse_hold_len: got %0d expected 30", rel_h); end
        n_checks++; if ({rel_ev, rel_sh, rel_md, rel_lg} !== 4'b0000) begin n_fail++; $display("FAIL pulse_release: got %b expected 0000", {rel_ev, rel_sh, rel_md, rel_lg}); end
        n_checks++; if (hold_short + hold_med + long_h.size() + post_cnt + other_cnt !== 0) begin n_fail++; $display("FAIL pulse_stray: got %0d expected 0", hold_short + hold_med + long_h.size() + post_cnt + other_cnt); end
    endtask

    task automatic test_repeat();
        int exp_h[6] = '{0, 10, 13, 16, 19, 22};
        int got;
        mode[3:2] = 2'b01;
        hold_channel(1, 25, -1, 2'b00);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL repeat_timeout: got %0d expected 0", timed_out); end
        n_checks++; if (ev_h.size() !== 6) begin n_fail++; $display("FAIL repeat_count: got %0d expected 6", ev_h.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < ev_h.size()) ? ev_h[i] : -1;
            n_checks++; if (got !== exp_h[i]) begin n_fail++; $display("FAIL repeat_pos%0d: got h=%0d expected h=%0d", i, got, exp_h[i]); end
        end
        n_checks++; if (rel_ev !== 1'b0) begin n_fail++; $display("FAIL repeat_release: got %b expected 0", rel_ev); end
        n_checks++; if (post_cnt + other_cnt !== 0) begin n_fail++; $display("FAIL repeat_stray: got %0d expected 0", post_cnt + other_cnt); end
    endtask

    task automatic test_classify();
        int   holds[7]   = '{15, 19, 20, 30, 50, 51, 60};
        logic exp_sh[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic exp_md[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int   exp_lh[7]  = '{-1, -1, -1, -1, -1, 50, 50};
        int   lh;
        mode[5:4] = 2'b10;
        for (int i = 0; i < 7; i++) begin
            hold_channel(2, holds[i], -1, 2'b00);
            lh = (long_h.size() > 0) ? long_h[0] : -1;
            n_checks++; if (rel_sh !== exp_sh[i]) begin n_fail++; $display("FAIL classify_short_h%0d: got %b expected %b", holds[i], rel_sh, exp_sh[i]); end
            n_checks++; if (rel_md !== exp_md[i]) begin n_fail++; $display("FAIL classify_medium_h%0d: got %b expected %b", holds[i], rel_md, exp_md[i]); end
            n_checks++; if (lh !== exp_lh[i]) begin n_fail++; $display("FAIL classify_long_h%0d: got h=%0d expected h=%0d", holds[i], lh, exp_lh[i]); end
            n_checks++; if (long_h.size() > 1 || hold_short + hold_med + ev_h.size() + post_cnt + other_cnt + int'(rel_ev) + int'(rel_lg) !== 0) begin n_fail++; $display("FAIL classify_stray_h%0d: got %0d stray pulses expected 0", holds[i], hold_short + hold_med + ev_h.size() + post_cnt + other_cnt); end
        end
    endtask

    task automatic test_mode_change();
        int p0, p1;
        mode[3:2] = 2'b01;
        hold_channel(1, 30, 12, 2'b00);
        p0 = (ev_h.size() > 0) ? ev_h[0] : -1;
        p1 = (ev_h.size() > 1) ? ev_h[1] : -1;
        n_checks++; if (ev_h.size() !== 2) begin n_fail++; $display("FAIL lockout_count: got %0d expected 2", ev_h.size()); end
        n_checks++; if (p0 !== 0 || p1 !== 10) begin n_fail++; $display("FAIL lockout_positions: got h=%0d,%0d expected h=0,10", p0, p1); end
        n_checks++; if ({rel_ev, rel_sh, rel_md, rel_lg} !== 4'b0000 || post_cnt !== 0) begin n_fail++; $display("FAIL lockout_release: got %b/%0d expected 0000/0", {rel_ev, rel_sh, rel_md, rel_lg}, post_cnt); end
        hold_channel(1, 10, -1, 2'b00);
        p0 = (ev_h.size() > 0) ? ev_h[0] : -1;
        n_checks++; if (ev_h.size() !== 1 || p0 !== 0) begin n_fail++; $display("FAIL lockout_next_pulse: got %0d pulses first h=%0d expected 1 at h=0", ev_h.size(), p0); end
    endtask

    task automatic test_reset_mid_hold();
        int d, n_ev, others;
        mode = 6'b100100;
        btn[0] = 1'b1;
        d = 0;
        while (level[0] !== 1'b1 && d < 20) begin tick(); d++; end
        n_checks++; if (d !== 4) begin n_fail++; $display("FAIL rst_first_rise: got %0d expected 4", d); end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        n_checks++; if ({level, ev, sh, md, lg} !== 15'd0) begin n_fail++; $display("FAIL rst_outputs_cleared: got %b expected all zero", {level, ev, sh, md, lg}); end
        rst = 1'b0;
        d = 0; n_ev = 0; others = 0;
        while (level[0] !== 1'b1 && d < 20) begin
            tick();
            d++;
            if (ev[0] === 1'b1) n_ev++;
            if (|((level | ev | sh | md | lg) & 3'b110)) others++;
        end
        n_checks++; if (d !== 4) begin n_fail++; $display("FAIL rst_re_rise: got %0d expected 4", d); end
        n_checks++; if (ev[0] !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_press: got %b expected 1", ev[0]); end
        repeat (8) begin
            tick();
            if (ev[0] === 1'b1) n_ev++;
            if (|((level | ev | sh | md | lg) & 3'b110)) others++;
        end
        btn[0] = 1'b0;
        repeat (8) begin
            tick();
            if (ev[0] === 1'b1) n_ev++;
            if (|((level | ev | sh | md | lg) & 3'b110)) others++;
        end
        n_checks++; if (n_ev !== 1) begin n_fail++; $display("FAIL rst_press_count: got %0d expected 1", n_ev); end
        n_checks++; if (others !== 0) begin n_fail++; $display("FAIL rst_idle_channels: got %0d active cycles expected 0", others); end
    endtask

    initial begin
        rst = 1'b1;
        btn = 3'b000;
        mode = 6'b111111;
        test_reset();
        test_glitch();
        test_pulse();
        test_repeat();
        test_classify();
        test_mode_change();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised, N-channel successor to the fixed five-button front end.
- Each channel has the following, all selectable at run time through a per-channel mode field:
  - a debouncer;
  - press-pulse generation;
  - DAS/ARR auto-repeat;
  - short/medium/long press-duration classification.
- Sits between board pushbuttons and game/menu control logic.
- Replaces hard-wired per-button debounce, pulse, auto-shift and button-sharing instances with one uniform block.

Parameters:
- N_BTN, 5: number of independent channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a new level (>=2).
- DAS_CYCLES, 10000000: hold time before the first auto-repeat pulse (>=1).
- ARR_CYCLES, 3000000: period between subsequent auto-repeat pulses (>=1).
- MEDIUM_CYCLES, 50000000: minimum hold for a medium press (>=1).
- LONG_CYCLES, 150000000: hold at which a long press fires (>MEDIUM_CYCLES).

Ports:
- clk_in, input, 1: system clock.
- reset_in, input, 1: synchronous, active-high reset.
- btn_in, input, N_BTN: raw asynchronous button levels, bit i = channel i.
- mode_in, input, 2*N_BTN: bits [2i+1:2i] set channel i mode. 00 = PULSE, 01 = REPEAT, 10 = CLASSIFY, 11 = OFF.
- level_out, output, N_BTN: debounced level.
- event_out, output, N_BTN: one-cycle press pulse (PULSE mode) or press/repeat pulses (REPEAT mode).
- short_out, output, N_BTN: one-cycle pulse, CLASSIFY mode only.
- medium_out, output, N_BTN: one-cycle pulse, CLASSIFY mode only.
- long_out, output, N_BTN: one-cycle pulse, CLASSIFY mode only.

Behaviour:
- Single clock domain. Reset is synchronous, active-high on reset_in. All outputs are registered.
- Reset state: all outputs 0; all debounce and hold counters 0; every channel FSM in IDLE with clean level 0.
- Counter widths are localparams, $clog2(max count + 1). Counters saturate and never wrap.

Debounce, per channel:
- r = sampled input.
- If r != clean, increment dcnt; otherwise clear dcnt.
- When r != clean and dcnt == DEBOUNCE_CYCLES-1, toggle clean and clear dcnt.
- level_out = clean. It changes exactly DEBOUNCE_CYCLES cycles after r becomes stable.
- Any single-cycle reversion restarts the count.

Hold count h, per channel:
- 0 in the first cycle level_out == 1.
- Increments each cycle while level_out stays 1; saturates at LONG_CYCLES.

FSM per channel, states IDLE, HELD, LOCKOUT:
- IDLE -> HELD on level_out rising (first high cycle); latch the channel's mode at this point.
- HELD -> IDLE on level_out falling.
- HELD -> LOCKOUT if mode_in for the channel differs from the latched mode while level_out == 1. LOCKOUT suppresses all events.
- LOCKOUT -> IDLE on level_out falling; no release event is produced.

Events, all registered, asserted in the same cycle as the qualifying level_out value:
- PULSE: event_out = 1 in the cycle h == 0 only.
- REPEAT: event_out = 1 at h == 0, h == DAS_CYCLES, and h == DAS_CYCLES + k*ARR_CYCLES for k >= 1.
  - For repeats, h uses a separate repeat counter that is not capped at LONG_CYCLES.
- CLASSIFY, while held: long_out = 1 in the cycle h == LONG_CYCLES; the channel is then flagged long_done.
- CLASSIFY, in the first cycle level_out == 0 after a hold of H high cycles, if long_done was not set:
  - short_out if H < MEDIUM_CYCLES;
  - otherwise medium_out.
- OFF: level_out still valid; all event outputs 0.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Reset mid-hold:
  - all outputs go to 0 in the cycle after reset_in is sampled high;
  - a button still held after reset re-debounces from clean = 0 and produces a fresh press.

Optional Feature:
- Macro BTN_SYNC_EN.
- Defined: btn_in passes through a two-flop synchroniser per channel before debounce. Every output latency grows by exactly 2 cycles. The synchroniser flops reset to 0.
- Undefined: btn_in feeds the debouncer directly. The integrator guarantees a synchronous source.

Test Plan:
All scenarios use N_BTN = 3, DEBOUNCE_CYCLES = 4, DAS_CYCLES = 10, ARR_CYCLES = 3, MEDIUM_CYCLES = 20, LONG_CYCLES = 50, BTN_SYNC_EN undefined.
1. Glitch rejection: ch0 btn_in high for 3 cycles, then low -> level_out[0] stays 0 and no events. Then hold high -> level_out[0] rises exactly 4 cycles after btn_in.
2. PULSE: ch0 mode 00, hold 30 cycles -> event_out[0] high for exactly one cycle, coincident with the first level_out[0] = 1 cycle; nothing on release.
3. REPEAT: ch1 mode 01, hold 25 high cycles -> event_out[1] pulses at h = 0, 10, 13, 16, 19, 22 (6 pulses).
4. CLASSIFY: ch2 mode 10.
   - Hold 15 -> short_out[2] once on release.
   - Hold 30 -> medium_out[2] once on release.
   - Hold 60 -> long_out[2] at h = 50 and no pulse on release.
5. Mode change mid-hold: ch1 in REPEAT, switch to 00 at h = 12 -> no further event_out[1] until release; the next press behaves as PULSE.
6. Reset mid-hold: assert reset_in at h = 5 with btn_in held -> all outputs 0 the next cycle. After reset drops, level_out rises 4 cycles later with one fresh press event. Simultaneously, other channels that were idle remain silent.
